exc_ctrl: RTL and testbench

Trap and return sequencer for the machine-mode CSR file. It accepts exception flags and `mret` from the execute stage and selects the highest-priority cause. It computes the new `mepc`/`mcause`/`mtval`/`mstatus` values and drives the CSR file's exception write port and return-address select. It also stalls, flushes and redirects the pipeline over a fixed three-state sequence.

---
 rtl/exc_ctrl_if.sv | 36 +++
 rtl/exc_ctrl.sv | 127 ++++++++++++
 tb/tb_exc_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/exc_ctrl_if.sv
// Execute-stage / CSR-file side of the trap sequencer: requests and CSR read data in, CSR write port and pipeline control out.
// master = pipeline and CSR file side, slave = exc_ctrl.
interface exc_ctrl_if;
    logic [5:0]  exc_i;
    logic        mret_i;
    logic [31:0] pc_i;
    logic [31:0] tval_i;
    logic [31:0] csr_mstatus_i;
    logic [31:0] csr_mepc_i;
    logic [31:0] csr_mcause_i;
    logic [31:0] csr_mtval_i;

    logic        we_exc_o;
    logic [31:0] mcause_d_o;
    logic [31:0] mepc_d_o;
    logic [31:0] mstatus_d_o;
    logic [31:0] mtval_d_o;
    logic        sel_exc_nret_o;
    logic        stall_o;
    logic        flush_o;
    logic        redirect_o;

    modport master (
        output exc_i, mret_i, pc_i, tval_i,
               csr_mstatus_i, csr_mepc_i, csr_mcause_i, csr_mtval_i,
        input  we_exc_o, mcause_d_o, mepc_d_o, mstatus_d_o, mtval_d_o,
               sel_exc_nret_o, stall_o, flush_o, redirect_o
    );

    modport slave (
        input  exc_i, mret_i, pc_i, tval_i,
               csr_mstatus_i, csr_mepc_i, csr_mcause_i, csr_mtval_i,
        output we_exc_o, mcause_d_o, mepc_d_o, mstatus_d_o, mtval_d_o,
               sel_exc_nret_o, stall_o, flush_o, redirect_o
    );
endinterface

// File: rtl/exc_ctrl.sv
// Machine-mode trap/mret sequencer: IDLE -> WRITE (CSR write, flush) -> REDIRECT (PC load), 3-cycle turnaround.
// No backpressure input; the pipeline is held via stall_o and requests outside IDLE are ignored.
module exc_ctrl (
    input  logic       clk_i,
    input  logic       rst_i,
    exc_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, WRITE, REDIRECT} state_t;

    state_t      state;
    logic        is_ret;

    logic        accept;
    logic        is_trap;
    logic [31:0] trap_cause;
    logic [31:0] trap_tval;
    logic [31:0] trap_mstatus;
    logic [31:0] ret_mstatus;

    assign is_trap = |bus.exc_i;
    assign accept  = is_trap | bus.mret_i;

    // Lowest exc_i bit wins; ebreak/ecall carry no trap value.
    always_comb begin
        trap_cause = 32'd0;
        trap_tval  = bus.tval_i;
        if (bus.exc_i[0]) begin
            trap_cause = 32'd0;
        end else if (bus.exc_i[1]) begin
            trap_cause = 32'd2;
        end else if (bus.exc_i[2]) begin
            trap_cause = 32'd3;
            trap_tval  = 32'd0;
        end else if (bus.exc_i[3]) begin
            trap_cause = 32'd11;
            trap_tval  = 32'd0;
        end else if (bus.exc_i[4]) begin
            trap_cause = 32'd4;
        end else if (bus.exc_i[5]) begin
            trap_cause = 32'd6;
        end
    end

    always_comb begin
        trap_mstatus        = bus.csr_mstatus_i;
        trap_mstatus[7]     = bus.csr_mstatus_i[3];
        trap_mstatus[3]     = 1'b0;
        trap_mstatus[12:11] = 2'b11;

        ret_mstatus         = bus.csr_mstatus_i;
        ret_mstatus[3]      = bus.csr_mstatus_i[7];
        ret_mstatus[7]      = 1'b1;
        ret_mstatus[12:11]  = 2'b11;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state              <= IDLE;
            is_ret             <= 1'b0;
            bus.we_exc_o       <= 1'b0;
            bus.flush_o        <= 1'b0;
            bus.stall_o        <= 1'b0;
            bus.redirect_o     <= 1'b0;
            bus.sel_exc_nret_o <= 1'b0;
            bus.mcause_d_o     <= 32'd0;
            bus.mepc_d_o       <= 32'd0;
            bus.mstatus_d_o    <= 32'd0;
            bus.mtval_d_o      <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    bus.we_exc_o       <= 1'b0;
                    bus.flush_o        <= 1'b0;
                    bus.stall_o        <= 1'b0;
                    bus.redirect_o     <= 1'b0;
                    bus.sel_exc_nret_o <= 1'b0;
                    if (accept) begin
                        state              <= WRITE;
                        is_ret             <= ~is_trap;
                        bus.we_exc_o       <= 1'b1;
                        bus.flush_o        <= 1'b1;
                        bus.stall_o        <= 1'b1;
                        bus.sel_exc_nret_o <= ~is_trap;
                        if (is_trap) begin
                            bus.mcause_d_o  <= trap_cause;
                            bus.mepc_d_o    <= {bus.pc_i[31:2], 2'b00};
                            bus.mtval_d_o   <= trap_tval;
                            bus.mstatus_d_o <= trap_mstatus;
                        end else begin
                            // mret rewrites all four CSRs, so the untouched ones pass through.
                            bus.mcause_d_o  <= bus.csr_mcause_i;
                            bus.mepc_d_o    <= bus.csr_mepc_i;
                            bus.mtval_d_o   <= bus.csr_mtval_i;
                            bus.mstatus_d_o <= ret_mstatus;
                        end
                    end
                end
                WRITE: begin
                    state              <= REDIRECT;
                    bus.we_exc_o       <= 1'b0;
                    bus.flush_o        <= 1'b0;
                    bus.stall_o        <= 1'b1;
                    bus.redirect_o     <= 1'b1;
                    bus.sel_exc_nret_o <= is_ret;
                end
                REDIRECT: begin
                    state              <= IDLE;
                    bus.we_exc_o       <= 1'b0;
                    bus.flush_o        <= 1'b0;
                    bus.stall_o        <= 1'b0;
                    bus.redirect_o     <= 1'b0;
                    bus.sel_exc_nret_o <= 1'b0;
                end
                default: begin
                    state              <= IDLE;
                    bus.we_exc_o       <= 1'b0;
                    bus.flush_o        <= 1'b0;
                    bus.stall_o        <= 1'b0;
                    bus.redirect_o     <= 1'b0;
                    bus.sel_exc_nret_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: expected per-cycle outputs are queued as stimulus is driven and popped each cycle.
module tb_exc_ctrl;

    logic clk_i = 1'b0;
    logic rst_i;

    exc_ctrl_if bus ();

    exc_ctrl dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic        flush;
        logic        stall;
        logic        redir;
        logic        sel;
        logic [31:0] mcause;
        logic [31:0] mepc;
        logic [31:0] mstatus;
        logic [31:0] mtval;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
        end
    endtask

    task automatic push(input logic we, input logic fl, input logic st, input logic rd, input logic sel,
                        input logic [31:0] mc, input logic [31:0] me, input logic [31:0] ms, input logic [31:0] mt);
        exp_t e;
        e.we = we; e.flush = fl; e.stall = st; e.redir = rd; e.sel = sel;
        e.mcause = mc; e.mepc = me; e.mstatus = ms; e.mtval = mt;
        sb.push_back(e);
    endtask

    // Advance one cycle and compare against the oldest queued expectation, sampling at negedge.
    task automatic step_check(input string tag);
        exp_t e;
        @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL %s.queue observed=empty expected=entry", tag);
        end else begin
            passes++;
            e = sb.pop_front();
            chk(tag, "we_exc",   {31'd0, bus.we_exc_o},       {31'd0, e.we});
            chk(tag, "flush",    {31'd0, bus.flush_o},        {31'd0, e.flush});
            chk(tag, "stall",    {31'd0, bus.stall_o},        {31'd0, e.stall});
            chk(tag, "redirect", {31'd0, bus.redirect_o},     {31'd0, e.redir});
            chk(tag, "sel",      {31'd0, bus.sel_exc_nret_o}, {31'd0, e.sel});
            chk(tag, "mcause",   bus.mcause_d_o,  e.mcause);
            chk(tag, "mepc",     bus.mepc_d_o,    e.mepc);
            chk(tag, "mstatus",  bus.mstatus_d_o, e.mstatus);
            chk(tag, "mtval",    bus.mtval_d_o,   e.mtval);
        end
    endtask

    task automatic quiet_inputs();
        bus.exc_i  = 6'd0;
        bus.mret_i = 1'b0;
    endtask

    // Request already driven for cycle N; check N+1 (WRITE), N+2 (REDIRECT), N+3 (IDLE, data held).
    task automatic run_seq(input string tag, input logic sel,
                           input logic [31:0] mc, input logic [31:0] me, input logic [31:0] ms, input logic [31:0] mt);
        push(1'b1, 1'b1, 1'b1, 1'b0, sel, mc, me, ms, mt);
        step_check({tag, "_w"});
        quiet_inputs();
        push(1'b0, 1'b0, 1'b1, 1'b1, sel, mc, me, ms, mt);
        step_check({tag, "_r"});
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mc, me, ms, mt);
        step_check({tag, "_i"});
    endtask

    initial begin
        rst_i = 1'b1;
        quiet_inputs();
        bus.pc_i = 32'd0;
        bus.tval_i = 32'd0;
        bus.csr_mstatus_i = 32'd0;
        bus.csr_mepc_i = 32'd0;
        bus.csr_mcause_i = 32'd0;
        bus.csr_mtval_i = 32'd0;

        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        step_check("reset");
        rst_i = 1'b0;
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        step_check("idle");

        // Illegal instruction trap
        bus.exc_i = 6'b000010;
        bus.pc_i = 32'h104;
        bus.tval_i = 32'hFFFF_FFFF;
        bus.csr_mstatus_i = 32'h8;
        run_seq("illegal", 1'b0, 32'd2, 32'h104, 32'h1880, 32'hFFFF_FFFF);

        // mret
        bus.mret_i = 1'b1;
        bus.csr_mstatus_i = 32'h1880;
        bus.csr_mepc_i = 32'h104;
        bus.csr_mcause_i = 32'd2;
        bus.csr_mtval_i = 32'h55;
        run_seq("mret", 1'b1, 32'd2, 32'h104, 32'h1888, 32'h55);

        // mret with MPIE clear and unrelated mstatus bits set
        bus.mret_i = 1'b1;
        bus.csr_mstatus_i = 32'h8000_0022;
        bus.csr_mepc_i = 32'h2000;
        bus.csr_mcause_i = 32'd11;
        bus.csr_mtval_i = 32'h0;
        run_seq("mret2", 1'b1, 32'd11, 32'h2000, 32'h8000_18A2, 32'h0);

        // All exceptions plus mret: fetch misaligned wins, no return
        bus.exc_i = 6'b111111;
        bus.mret_i = 1'b1;
        bus.pc_i = 32'h300;
        bus.tval_i = 32'h203;
        bus.csr_mstatus_i = 32'h0;
        run_seq("prio", 1'b0, 32'd0, 32'h300, 32'h1800, 32'h203);

        // ecall zeroes mtval
        bus.exc_i = 6'b001000;
        bus.pc_i = 32'h80;
        bus.tval_i = 32'hDEAD_BEEF;
        bus.csr_mstatus_i = 32'h8;
        run_seq("ecall", 1'b0, 32'd11, 32'h80, 32'h1880, 32'h0);

        // ebreak over ecall/load misaligned
        bus.exc_i = 6'b011100;
        bus.pc_i = 32'h1000;
        bus.tval_i = 32'h1234;
        bus.csr_mstatus_i = 32'h0;
        run_seq("ebreak", 1'b0, 32'd3, 32'h1000, 32'h1800, 32'h0);

        // Back-to-back store misaligned held for 4 cycles, unaligned PC
        bus.exc_i = 6'b100000;
        bus.pc_i = 32'h43;
        bus.tval_i = 32'h55;
        bus.csr_mstatus_i = 32'h0;
        push(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd6, 32'h40, 32'h1800, 32'h55);
        step_check("b2b_w1");
        push(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd6, 32'h40, 32'h1800, 32'h55);
        step_check("b2b_r1");
        bus.tval_i = 32'h77;
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd6, 32'h40, 32'h1800, 32'h55);
        step_check("b2b_i1");
        run_seq("b2b2", 1'b0, 32'd6, 32'h40, 32'h1800, 32'h77);

        // Reset during WRITE: no redirect afterwards, data cleared
        bus.exc_i = 6'b010000;
        bus.pc_i = 32'h200;
        bus.tval_i = 32'h1;
        bus.csr_mstatus_i = 32'h8;
        push(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd4, 32'h200, 32'h1880, 32'h1);
        step_check("rst_w");
        quiet_inputs();
        rst_i = 1'b1;
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        step_check("rst_mid");
        rst_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
            step_check("rst_after");
        end

        // Reset together with a request: request dropped
        bus.exc_i = 6'b000001;
        bus.pc_i = 32'h400;
        rst_i = 1'b1;
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        step_check("rst_req");
        quiet_inputs();
        rst_i = 1'b0;
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        step_check("rst_req2");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
